// File: rtl/b2b_merge_arbiter_if.sv
// Bundle of FIFO-side and output-side signals for the event merge arbiter.
// master is the arbiter side, slave is the environment side.
interface b2b_merge_arbiter_if #(
    parameter int unsigned DATA_WIDTH     = 65,
    parameter int unsigned TOTAL_CLUSTERS = 4,
    parameter int unsigned CNT_WIDTH      = 32
);
    localparam int unsigned GW = $clog2(TOTAL_CLUSTERS);

    logic [DATA_WIDTH-1:0]     in_data [TOTAL_CLUSTERS];
    logic [TOTAL_CLUSTERS-1:0] in_empty;
    logic [TOTAL_CLUSTERS-1:0] in_req;
    logic [DATA_WIDTH-1:0]     out_data;
    logic                      out_wren;
    logic                      out_almost_full;
    logic                      grant_valid;
    logic [GW-1:0]             grant_id;
    logic [CNT_WIDTH-1:0]      event_count;
    logic                      timeout_err;

    modport master (
        input  in_data, in_empty, out_almost_full,
        output in_req, out_data, out_wren, grant_valid, grant_id, event_count, timeout_err
    );

    modport slave (
        output in_data, in_empty, out_almost_full,
        input  in_req, out_data, out_wren, grant_valid, grant_id, event_count, timeout_err
    );
endinterface

// File: rtl/b2b_merge_arbiter.sv
// Round-robin merge of N FWFT event FIFOs into one output FIFO; events are forwarded
// atomically, with a mid-event starvation timeout that abandons a stalled input.
module b2b_merge_arbiter #(
    parameter int unsigned DATA_WIDTH     = 65,
    parameter int unsigned TOTAL_CLUSTERS = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                b2b_clk,
    input  logic                b2b_srst,
    b2b_merge_arbiter_if.master bus
);
    localparam int unsigned GW = $clog2(TOTAL_CLUSTERS);
    localparam int unsigned SW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                    state;
    logic [GW-1:0]             last_grant;
    logic [GW-1:0]             grant_id;
    logic [SW-1:0]             stall_cnt;
    logic [DATA_WIDTH-1:0]     out_data;
    logic                      out_wren;
    logic                      grant_valid;
    logic [CNT_WIDTH-1:0]      event_count;
    logic                      timeout_err;

    logic [GW-1:0]             scan_id;
    logic [GW-1:0]             idx;
    logic                      any_ready;
    logic [TOTAL_CLUSTERS-1:0] req;
    logic                      pop;
    logic [DATA_WIDTH-1:0]     head;
    logic                      eoe;

    // Next grant: first non-empty input after last_grant, wrapping.
    always_comb begin
        scan_id   = last_grant;
        any_ready = 1'b0;
        idx       = '0;
        for (int unsigned i = 1; i <= TOTAL_CLUSTERS; i++) begin
            idx = GW'((32'(last_grant) + i) % TOTAL_CLUSTERS);
            if (!any_ready && !bus.in_empty[idx]) begin
                scan_id   = idx;
                any_ready = 1'b1;
            end
        end
    end

    // Pop strobe is combinational so the FWFT head is consumed on the same edge.
    always_comb begin
        req  = '0;
        head = bus.in_data[grant_id];
        eoe  = head[DATA_WIDTH-1];
        if (state == STREAM && !b2b_srst && !bus.in_empty[grant_id] && !bus.out_almost_full) begin
            req[grant_id] = 1'b1;
        end
        pop = |req;
    end

    always_ff @(posedge b2b_clk) begin
        if (b2b_srst) begin
            state       <= IDLE;
            last_grant  <= GW'(TOTAL_CLUSTERS - 1);
            grant_id    <= '0;
            grant_valid <= 1'b0;
            stall_cnt   <= '0;
            out_wren    <= 1'b0;
            out_data    <= '0;
            event_count <= '0;
            timeout_err <= 1'b0;
        end else begin
            out_wren <= pop;
            if (pop) begin
                out_data <= head;
            end
            unique case (state)
                IDLE: begin
                    if (!bus.out_almost_full && any_ready) begin
                        grant_id    <= scan_id;
                        grant_valid <= 1'b1;
                        stall_cnt   <= '0;
                        state       <= STREAM;
                    end
                end
                STREAM: begin
                    if (pop) begin
                        stall_cnt <= '0;
                        if (eoe) begin
                            state       <= IDLE;
                            grant_valid <= 1'b0;
                            last_grant  <= grant_id;
                            event_count <= event_count + CNT_WIDTH'(1);
                        end
                    end else if (!bus.out_almost_full && bus.in_empty[grant_id]) begin
                        // Backpressure stalls are excluded; only genuine starvation counts.
                        if (stall_cnt == SW'(TIMEOUT_CYCLES - 1)) begin
                            timeout_err <= 1'b1;
                            last_grant  <= grant_id;
                            grant_valid <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            stall_cnt <= stall_cnt + SW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_req      = req;
    assign bus.out_data    = out_data;
    assign bus.out_wren    = out_wren;
    assign bus.grant_valid = grant_valid;
    assign bus.grant_id    = grant_id;
    assign bus.event_count = event_count;
    assign bus.timeout_err = timeout_err;
endmodule

// File: tb/tb_b2b_merge_arbiter.sv
// Bench for b2b_merge_arbiter: software FIFOs feed the inputs and an event-level
// reference model predicts every output each cycle.
module tb_b2b_merge_arbiter;
    localparam int unsigned DW = 16;
    localparam int unsigned N  = 4;
    localparam int unsigned TO = 8;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic srst;
    logic afull;
    always #5 clk = ~clk;

    b2b_merge_arbiter_if #(.DATA_WIDTH(DW), .TOTAL_CLUSTERS(N), .CNT_WIDTH(CW)) bus ();

    b2b_merge_arbiter #(
        .DATA_WIDTH(DW), .TOTAL_CLUSTERS(N), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
    ) dut (
        .b2b_clk (clk),
        .b2b_srst(srst),
        .bus     (bus)
    );

    // Source FIFOs and model of the arbiter's observable behaviour.
    logic [DW-1:0] src_q [N][$];
    int            grants[$];
    int            owner, last, gid, starve, count, wren_total;
    bit            err, wren;
    logic [DW-1:0] outd;
    int            checks   = 0;
    int            failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = -1; last = N - 1; gid = 0; starve = 0; count = 0;
        err = 1'b0; wren = 1'b0; outd = '0;
    endtask

    task automatic push_word(input int k, input bit eoe);
        logic [DW-1:0] w;
        w = {eoe, 15'($urandom)};
        src_q[k].push_back(w);
    endtask

    task automatic push_event(input int k, input int len);
        for (int j = 0; j < len; j++) push_word(k, j == len - 1);
    endtask

    function automatic bit all_empty();
        for (int k = 0; k < N; k++) if (src_q[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [N-1:0] exp_req();
        logic [N-1:0] r;
        r = '0;
        if (!srst && owner >= 0 && !afull && src_q[owner].size() != 0) r[owner] = 1'b1;
        return r;
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            bus.in_empty[k] = (src_q[k].size() == 0);
            bus.in_data[k]  = (src_q[k].size() != 0) ? src_q[k][0] : '0;
        end
        bus.out_almost_full = afull;
    endtask

    // Advance the model across one rising edge using the pre-edge inputs.
    task automatic update();
        logic [N-1:0]  r;
        logic [DW-1:0] w;
        bit            found;
        r = exp_req();
        if (srst) begin
            model_reset();
            return;
        end
        wren = 1'b0;
        if (owner < 0) begin
            found = 1'b0;
            if (!afull) begin
                for (int i = 1; i <= N; i++) begin
                    int k;
                    k = (last + i) % N;
                    if (!found && src_q[k].size() != 0) begin
                        found = 1'b1; owner = k; gid = k; starve = 0; grants.push_back(k);
                    end
                end
            end
        end else if (r != '0) begin
            w = src_q[owner].pop_front();
            wren = 1'b1; outd = w; starve = 0; wren_total++;
            if (w[DW-1]) begin
                count = (count + 1) % (1 << CW);
                last  = owner;
                owner = -1;
            end
        end else if (!afull) begin
            starve++;
            if (starve == TO) begin
                err = 1'b1; last = owner; owner = -1;
            end
        end
    endtask

    task automatic step();
        drive();
        #1;
        chk("in_req",      64'(bus.in_req),      64'(exp_req()));
        chk("out_wren",    64'(bus.out_wren),    64'(wren));
        chk("out_data",    64'(bus.out_data),    64'(outd));
        chk("grant_valid", 64'(bus.grant_valid), 64'(owner >= 0));
        chk("grant_id",    64'(bus.grant_id),    64'(gid));
        chk("event_count", 64'(bus.event_count), 64'(count));
        chk("timeout_err", 64'(bus.timeout_err), 64'(err));
        @(posedge clk);
        update();
        @(negedge clk);
    endtask

    task automatic run_until_idle(input int max_cycles, input string tag);
        bit done;
        done = 1'b0;
        for (int c = 0; c < max_cycles && !done; c++) begin
            step();
            done = (owner < 0) && all_empty();
        end
        checks++;
        assert (done) else begin
            failures++;
            $error("FAIL %s: observed=busy expected=idle within %0d cycles", tag, max_cycles);
        end
    endtask

    initial begin
        srst = 1'b1;
        afull = 1'b0;
        model_reset();
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset values
        step();
        chk("rst_event_count", 64'(bus.event_count), 64'd0);
        chk("rst_grant_valid", 64'(bus.grant_valid), 64'd0);
        srst = 1'b0;

        // One 3-word event on every input: strict rotation 0..3
        wren_total = 0;
        grants.delete();
        for (int k = 0; k < N; k++) push_event(k, 3);
        run_until_idle(80, "s1_drain");
        step();
        chk("s1_grants", 64'(grants.size()), 64'd4);
        for (int i = 0; i < grants.size(); i++) chk("s1_order", 64'(grants[i]), 64'(i));
        chk("s1_wren_total", 64'(wren_total), 64'd12);
        chk("s1_event_count", 64'(bus.event_count), 64'd4);

        // Input 2 starves mid-event while input 0 and 3 wait
        push_word(2, 1'b0);
        for (int c = 0; c < 10 && src_q[2].size() != 0; c++) step();
        push_event(0, 2);
        push_event(3, 2);
        grants.delete();
        repeat (5) step();
        chk("s2_hold_grant", 64'(bus.grant_id), 64'd2);
        push_word(2, 1'b1);
        run_until_idle(60, "s2_drain");
        chk("s2_next_grant", 64'(grants[0]), 64'd3);
        chk("s2_then_grant", 64'(grants[1]), 64'd0);
        chk("s2_no_error", 64'(bus.timeout_err), 64'd0);

        // Backpressure for 10 cycles mid-event
        grants.delete();
        push_event(1, 4);
        for (int c = 0; c < 10 && src_q[1].size() != 3; c++) step();
        afull = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("s3_req_paused", 64'(bus.in_req), 64'd0);
        end
        chk("s3_grant_kept", 64'(bus.grant_valid), 64'd1);
        afull = 1'b0;
        run_until_idle(40, "s3_drain");
        chk("s3_single_grant", 64'(grants.size()), 64'd1);
        chk("s3_same_input", 64'(grants[0]), 64'd1);
        chk("s3_no_timeout", 64'(bus.timeout_err), 64'd0);

        // Starvation timeout on input 0
        push_word(0, 1'b0);
        for (int c = 0; c < 10 && src_q[0].size() != 0; c++) step();
        repeat (7) step();
        chk("s4_before_limit", 64'(bus.timeout_err), 64'd0);
        step();
        chk("s4_timeout", 64'(bus.timeout_err), 64'd1);
        chk("s4_idle", 64'(bus.grant_valid), 64'd0);
        grants.delete();
        push_event(0, 2);
        push_event(1, 2);
        run_until_idle(60, "s4_drain");
        chk("s4_rotate", 64'(grants[0]), 64'd1);
        chk("s4_rotate_wrap", 64'(grants[1]), 64'd0);
        chk("s4_sticky", 64'(bus.timeout_err), 64'd1);

        // Reset pulse during a pop
        push_event(2, 3);
        push_event(0, 1);
        for (int c = 0; c < 10 && src_q[2].size() != 2; c++) step();
        srst = 1'b1;
        step();
        srst = 1'b0;
        chk("s5_wren_after_rst", 64'(bus.out_wren), 64'd0);
        chk("s5_count_after_rst", 64'(bus.event_count), 64'd0);
        chk("s5_err_cleared", 64'(bus.timeout_err), 64'd0);
        grants.delete();
        run_until_idle(60, "s5_drain");
        chk("s5_first_grant", 64'(grants[0]), 64'd0);

        // Counter wrap: 16 single-word events from a clean reset
        srst = 1'b1;
        step();
        srst = 1'b0;
        for (int e = 0; e < 16; e++) push_word(int'($urandom_range(N - 1, 0)), 1'b1);
        run_until_idle(200, "s6_drain");
        step();
        chk("s6_wrapped", 64'(bus.event_count), 64'd0);

        // Random traffic with random backpressure and occasional starvation
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(3, 0) == 0)
                push_word(int'($urandom_range(N - 1, 0)), $urandom_range(2, 0) == 0);
            afull = ($urandom_range(4, 0) == 0);
            step();
        end
        afull = 1'b0;
        run_until_idle(600, "s7_drain");
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/b2b_merge_arbiter.md
B2B_MERGE_ARBITER -- requirements
Module: b2b_merge_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 65: event word width; bit DATA_WIDTH-1 is the end-of-event (EOE) marker.
REQ-002 The block SHALL have parameter TOTAL_CLUSTERS, default 4: number of requesting input FIFOs (N), with N >= 2.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1024: mid-event starvation limit, with TIMEOUT_CYCLES >= 2.
REQ-004 The block SHALL have parameter CNT_WIDTH, default 32: width of the event counter.
REQ-005 The block SHALL have port b2b_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port b2b_srst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port in_data[N], input, DATA_WIDTH bits each: first-word-fall-through FIFO head word, valid when !in_empty.
REQ-008 The block SHALL have port in_empty[N], input, 1 bit each: FIFO empty flag.
REQ-009 The block SHALL have port in_req[N], output, 1 bit each: pop strobe; the head word is consumed on that edge.
REQ-010 The block SHALL have port out_data, output, DATA_WIDTH bits: forwarded word to the output board FIFO.
REQ-011 The block SHALL have port out_wren, output, 1 bit: write enable for out_data.
REQ-012 The block SHALL have port out_almost_full, input, 1 bit: output FIFO backpressure.
REQ-013 The block SHALL have port grant_valid, output, 1 bit: state is STREAM.
REQ-014 The block SHALL have port grant_id, output, clog2(N) bits: currently or last granted input.
REQ-015 The block SHALL have port event_count, output, CNT_WIDTH bits: number of complete events forwarded.
REQ-016 The block SHALL have port timeout_err, output, 1 bit: sticky starvation error.

Function
REQ-017 The block SHALL implement an FSM with states IDLE and STREAM, and SHALL hold registers last_grant, grant_id and stall_cnt.
REQ-018 IDLE: when !out_almost_full and any in_empty[k]==0, the block SHALL register grant_id = first non-empty index scanning last_grant+1, +2, ... modulo N, and SHALL enter STREAM next cycle.
REQ-019 IDLE: when out_almost_full==1 or all inputs are empty, the block SHALL stay in IDLE with no grant.
REQ-020 in_req[k] SHALL be asserted only in STREAM, only for k==grant_id, and exactly when !in_empty[k] && !out_almost_full (combinational).
REQ-021 in_req SHALL be all-zero in IDLE and during reset.
REQ-022 Each pop SHALL produce out_data = popped word and out_wren=1 on the following cycle (latency 1); otherwise out_wren=0 and out_data holds its last value.
REQ-023 A popped word with EOE=1 SHALL return the FSM to IDLE next cycle, set last_grant = grant_id, and increment event_count modulo 2^CNT_WIDTH.
REQ-024 Events SHALL be atomic: no word from another input is forwarded between the first word and the EOE word of a granted event.
REQ-025 Minimum gap between consecutive events SHALL be one IDLE cycle (no pop).
REQ-026 stall_cnt SHALL clear on every pop and on entry to STREAM, and SHALL increment each STREAM cycle with in_empty[grant_id]==1 && !out_almost_full.
REQ-027 Cycles stalled by out_almost_full SHALL neither count toward nor clear stall_cnt.
REQ-028 When stall_cnt reaches TIMEOUT_CYCLES-1 and the input is still empty, the block SHALL set timeout_err=1, set last_grant = grant_id, and return to IDLE next cycle; no word is synthesised.
REQ-029 timeout_err SHALL clear only on reset.
REQ-030 If EOE pop and the timeout condition coincide, EOE takes precedence (a pop clears stall): event_count increments and no error is raised.
REQ-031 A single-word event (EOE on the first word) SHALL be legal.
REQ-032 out_almost_full rising mid-event SHALL pause pops and keep the grant; forwarding SHALL resume on the same input.

Reset
REQ-033 While b2b_srst=1, at the next edge the block SHALL set: state=IDLE, last_grant=N-1 (first scan starts at 0), grant_id=0, grant_valid=0, stall_cnt=0, out_wren=0, out_data=0, event_count=0, timeout_err=0.
REQ-034 Reset mid-event SHALL abandon the event; no out_wren SHALL be asserted in the cycle after reset, even if a pop preceded the reset edge.

Verification
REQ-035 Scenario: all 4 inputs each hold one 3-word event, out_almost_full=0 -> grants in order 0,1,2,3; 12 out_wren; event_count=4; words in order, never interleaved.
REQ-036 Scenario: input 2 emits word1, goes empty for 5 cycles, then sends EOE while input 0 is non-empty -> no input-0 word appears before input-2 EOE; next grant is 3 if non-empty, else 0.
REQ-037 Scenario: out_almost_full=1 for 10 cycles mid-event -> in_req=0 and out_wren=0 throughout, stall_cnt unchanged, no timeout; resumes on the same input.
REQ-038 Scenario: TIMEOUT_CYCLES=8, granted input goes empty after a non-EOE word -> timeout_err=1 after 8 stall cycles, IDLE; the next grant rotates past it; the flag stays 1.
REQ-039 Scenario: b2b_srst pulsed during a pop cycle -> next cycle out_wren=0, event_count=0, and the first grant after release goes to input 0 if non-empty.
REQ-040 Scenario: event_count preset near wrap (CNT_WIDTH=4, 16 events) -> reads 0 after the 16th EOE.
